// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS next-PC path: decode transfer types,
// sequencer states and the default reset/exception vectors.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    DT_BEQ  = 3'd0,
    DT_BNE  = 3'd1,
    DT_BGEZ = 3'd2,
    DT_BGTZ = 3'd3,
    DT_BLEZ = 3'd4,
    DT_BLTZ = 3'd5,
    DT_J    = 3'd6,
    DT_JR   = 3'd7
  } dec_type_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0040_0004;

  // Word offset of a conditional branch, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Fetch/decode bus between the pipeline front end (master) and the
// next-PC sequencer (slave).
interface branch_pc_sequencer_if;

  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        dec_valid;
  logic [2:0]  dec_type;
  logic [31:0] dec_pc;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        opnd_ready;
  logic        exc_req;
  logic        stall;
  logic        flush;
  logic        exc_jr;
  logic [31:0] taken_cnt;

  modport master (
    output imem_ready, dec_valid, dec_type, dec_pc, imm16, instr_index,
           rs_val, rt_val, opnd_ready, exc_req,
    input  pc, fetch_valid, stall, flush, exc_jr, taken_cnt
  );

  modport slave (
    input  imem_ready, dec_valid, dec_type, dec_pc, imm16, instr_index,
           rs_val, rt_val, opnd_ready, exc_req,
    output pc, fetch_valid, stall, flush, exc_jr, taken_cnt
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch/jump resolution: taken decision, redirect target and
// misaligned-JR detection for the instruction currently in decode.
module branch_cond_eval
  import mips_ctrl_pkg::*;
(
  input  logic [2:0]  dec_type,
  input  logic [31:0] dec_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic        jr_misaligned,
  output logic [31:0] target
);

  logic [31:0]        pc_plus4;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;

  assign pc_plus4 = dec_pc + 32'd4;
  assign rs_s     = rs_val;
  assign rt_s     = rt_val;

  always_comb begin
    taken         = 1'b0;
    jr_misaligned = 1'b0;
    target        = pc_plus4 + branch_offset(imm16);
    case (dec_type_e'(dec_type))
      DT_BEQ:  taken = (rs_s == rt_s);
      DT_BNE:  taken = (rs_s != rt_s);
      DT_BGEZ: taken = (rs_s >= 32'sd0);
      DT_BGTZ: taken = (rs_s >  32'sd0);
      DT_BLEZ: taken = (rs_s <= 32'sd0);
      DT_BLTZ: taken = (rs_s <  32'sd0);
      DT_J: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], instr_index, 2'b00};
      end
      DT_JR: begin
        // A misaligned register target becomes an exception, not a transfer.
        jr_misaligned = |rs_val[1:0];
        taken         = ~jr_misaligned;
        target        = rs_val;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Next-PC sequencer: owns the PC, resolves decode transfers and exceptions.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot fetch on taken redirects.
module branch_pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEFAULT_EXC_VEC
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_pc_sequencer_if.slave  bus
);

  seq_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] taken_cnt_q;
  logic        fetch_valid_q;
  logic        flush_q;
  logic        exc_jr_q;

  logic        taken;
  logic        jr_misaligned;
  logic [31:0] target;
  logic        resolve;

  branch_cond_eval u_eval (
    .dec_type      (bus.dec_type),
    .dec_pc        (bus.dec_pc),
    .imm16         (bus.imm16),
    .instr_index   (bus.instr_index),
    .rs_val        (bus.rs_val),
    .rt_val        (bus.rt_val),
    .taken         (taken),
    .jr_misaligned (jr_misaligned),
    .target        (target)
  );

  assign resolve = bus.dec_valid & bus.opnd_ready;

  // Stall releases in the very cycle operands arrive so decode resolves once.
  assign bus.stall       = ~bus.opnd_ready & (bus.dec_valid | (state_q == ST_BR_WAIT));
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.exc_jr      = exc_jr_q;
  assign bus.taken_cnt   = taken_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_VEC;
      taken_cnt_q   <= 32'd0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      exc_jr_q      <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b1;
      flush_q       <= 1'b0;
      exc_jr_q      <= 1'b0;
      if (bus.exc_req) begin
        state_q <= ST_RUN;
        pc_q    <= EXC_VEC;
        flush_q <= 1'b1;
      end else if (resolve) begin
        state_q <= ST_RUN;
        if (jr_misaligned) begin
          pc_q     <= EXC_VEC;
          exc_jr_q <= 1'b1;
          flush_q  <= 1'b1;
        end else if (taken) begin
          pc_q        <= target;
          taken_cnt_q <= taken_cnt_q + 32'd1;
`ifdef BRANCH_DELAY_SLOT_EN
          flush_q     <= 1'b0;
`else
          flush_q     <= 1'b1;
`endif
        end else if (bus.imem_ready) begin
          pc_q <= pc_q + 32'd4;
        end
      end else if (bus.dec_valid) begin
        state_q <= ST_BR_WAIT;
      end else begin
        // Leaving BR_WAIT without a transfer still holds the PC for that cycle.
        state_q <= ST_RUN;
        if (state_q == ST_RUN && bus.imem_ready) begin
          pc_q <= pc_q + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed plus randomized bench for branch_pc_sequencer against a
// behavioural next-PC model.
module tb_branch_pc_sequencer;

  localparam logic [31:0] RST_V = 32'h0040_0000;
  localparam logic [31:0] EXC_V = 32'h0040_0004;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_pc_sequencer_if bus ();

  branch_pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: the PC, counter and pulses, plus "a branch is parked".
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_parked;
  bit          m_fv;
  bit          m_flush;
  bit          m_exc_jr;
  bit          m_stall;

  function automatic bit cond_met(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    int a;
    int b;
    a = int'(rs);
    b = int'(rt);
    case (kind)
      0: return a == b;
      1: return a != b;
      2: return a >= 0;
      3: return a > 0;
      4: return a <= 0;
      5: return a < 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] transfer_target(input int kind, input logic [31:0] dpc,
                                                  input logic [15:0] imm, input logic [25:0] idx,
                                                  input logic [31:0] rs);
    shortint off;
    logic [31:0] seq;
    off = imm;
    seq = dpc + 32'd4;
    if (kind == 6) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
    if (kind == 7) return rs;
    return seq + 32'(int'(off) * 4);
  endfunction

  task automatic model_step();
    int kind;
    kind = int'(bus.dec_type);
    if (!rst_n) begin
      m_pc = RST_V; m_cnt = 0; m_parked = 0; m_fv = 0; m_flush = 0; m_exc_jr = 0;
      return;
    end
    m_fv = 1; m_flush = 0; m_exc_jr = 0;
    if (bus.exc_req) begin
      m_pc = EXC_V; m_flush = 1; m_parked = 0;
    end else if (bus.dec_valid && bus.opnd_ready) begin
      m_parked = 0;
      if (kind == 7 && bus.rs_val[1:0] != 2'b00) begin
        m_pc = EXC_V; m_exc_jr = 1; m_flush = 1;
      end else if (cond_met(kind, bus.rs_val, bus.rt_val)) begin
        m_pc = transfer_target(kind, bus.dec_pc, bus.imm16, bus.instr_index, bus.rs_val);
        m_cnt = m_cnt + 1;
        m_flush = !DELAY_SLOT;
      end else if (bus.imem_ready) begin
        m_pc = m_pc + 4;
      end
    end else if (bus.dec_valid) begin
      m_parked = 1;
    end else begin
      if (!m_parked && bus.imem_ready) m_pc = m_pc + 4;
      m_parked = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic dv, input logic [2:0] kind, input logic [31:0] dpc,
                                input logic [15:0] imm, input logic [25:0] idx,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic rdy, input logic exc, input logic imr);
    bus.dec_valid   = dv;
    bus.dec_type    = kind;
    bus.dec_pc      = dpc;
    bus.imm16       = imm;
    bus.instr_index = idx;
    bus.rs_val      = rs;
    bus.rt_val      = rt;
    bus.opnd_ready  = rdy;
    bus.exc_req     = exc;
    bus.imem_ready  = imr;
  endtask

  task automatic run_cycle(input string tag);
    #2;
    m_stall = rst_n && !bus.opnd_ready && (bus.dec_valid || m_parked);
    if (rst_n) check({tag, ".stall"}, 32'(bus.stall), 32'(m_stall));
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".pc"}, bus.pc, m_pc);
    check({tag, ".flush"}, 32'(bus.flush), 32'(m_flush));
    check({tag, ".exc_jr"}, 32'(bus.exc_jr), 32'(m_exc_jr));
    check({tag, ".taken_cnt"}, bus.taken_cnt, m_cnt);
    check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(m_fv));
  endtask

  initial begin
    logic [31:0] dpc;
    logic        dv;
    logic [2:0]  kind;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] rt;
    checks = 0;
    failures = 0;
    m_parked = 0;
    m_stall = 0;

    // Reset held two cycles, then free-running fetch.
    rst_n = 1'b0;
    apply_stimulus(0, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1, 0, 1);
    run_cycle("rst0");
    run_cycle("rst1");
    check("reset.pc", bus.pc, 32'h0040_0000);
    check("reset.fetch_valid", 32'(bus.fetch_valid), 32'd0);
    rst_n = 1'b1;
    run_cycle("adv0");
    check("adv0.lit", bus.pc, 32'h0040_0004);
    run_cycle("adv1");
    check("adv1.lit", bus.pc, 32'h0040_0008);

    // BEQ taken with a negative offset.
    apply_stimulus(1, 3'd0, 32'h0040_0010, 16'hFFFC, 26'd0, 32'd5, 32'd5, 1, 0, 1);
    run_cycle("beq");
    check("beq.lit_pc", bus.pc, 32'h0040_0004);
    check("beq.lit_cnt", bus.taken_cnt, 32'd1);
    check("beq.lit_flush", 32'(bus.flush), DELAY_SLOT ? 32'd0 : 32'd1);
    apply_stimulus(0, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1, 0, 1);
    run_cycle("idle0");

    // BNE waits three cycles for operands, then falls through.
    dpc = m_pc - 32'd4;
    apply_stimulus(1, 3'd1, dpc, 16'h0010, 26'd0, 32'd1, 32'd1, 0, 0, 1);
    repeat (3) begin
      run_cycle("bne_wait");
      check("bne_wait.lit_pc", bus.pc, dpc + 32'd4);
    end
    apply_stimulus(1, 3'd1, dpc, 16'h0010, 26'd0, 32'd1, 32'd1, 1, 0, 1);
    run_cycle("bne_res");
    check("bne_res.lit_pc", bus.pc, dpc + 32'd8);
    check("bne_res.lit_cnt", bus.taken_cnt, 32'd1);

    // J into a new region, then a misaligned JR.
    apply_stimulus(1, 3'd6, 32'h0040_0020, 16'd0, 26'h010_0040, 32'd0, 32'd0, 1, 0, 1);
    run_cycle("j");
    check("j.lit_pc", bus.pc, 32'h0040_0100);
    apply_stimulus(1, 3'd7, 32'h0040_00FC, 16'd0, 26'd0, 32'h0040_0102, 32'd0, 1, 0, 1);
    run_cycle("jr_mis");
    check("jr_mis.lit_pc", bus.pc, 32'h0040_0004);
    check("jr_mis.lit_exc_jr", 32'(bus.exc_jr), 32'd1);
    check("jr_mis.lit_cnt", bus.taken_cnt, 32'd2);
    apply_stimulus(0, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1, 0, 1);
    run_cycle("idle1");

    // Exception beats a taken BGEZ resolving out of BR_WAIT.
    dpc = m_pc - 32'd4;
    apply_stimulus(1, 3'd2, dpc, 16'h0008, 26'd0, 32'd3, 32'd0, 0, 0, 1);
    run_cycle("bgez_wait");
    apply_stimulus(1, 3'd2, dpc, 16'h0008, 26'd0, 32'd3, 32'd0, 1, 1, 1);
    run_cycle("bgez_exc");
    check("bgez_exc.lit_pc", bus.pc, 32'h0040_0004);
    check("bgez_exc.lit_flush", 32'(bus.flush), 32'd1);
    check("bgez_exc.lit_cnt", bus.taken_cnt, 32'd2);
    apply_stimulus(0, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1, 0, 1);
    run_cycle("after_exc");
    check("after_exc.lit_pc", bus.pc, 32'h0040_0008);

    // Fetch not accepted for four cycles.
    apply_stimulus(0, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1, 0, 0);
    repeat (4) begin
      run_cycle("hold");
      check("hold.lit_pc", bus.pc, 32'h0040_0008);
    end

    // Reset while parked in BR_WAIT.
    apply_stimulus(1, 3'd5, 32'h0040_0004, 16'h0004, 26'd0, 32'hFFFF_FFFF, 32'd0, 0, 0, 1);
    run_cycle("bltz_wait");
    rst_n = 1'b0;
    run_cycle("rst_mid");
    check("rst_mid.lit_pc", bus.pc, 32'h0040_0000);
    rst_n = 1'b1;

    // Randomized traffic; decode fields stay frozen while stalled.
    dv = 0; kind = 0; dpc = 0; imm = 0; idx = 0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!m_stall) begin
        dv   = ($urandom_range(0, 1) == 1);
        kind = 3'($urandom_range(0, 7));
        dpc  = m_pc - 32'd4;
        imm  = 16'($urandom);
        idx  = 26'($urandom);
      end
      rs = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 6)) - 32'd3;
      if (kind == 3'd7 && $urandom_range(0, 2) != 0) rs[1:0] = 2'b00;
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      apply_stimulus(dv, kind, dpc, imm, idx, rs, rt,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0);
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
Next-PC controller for the 54-instruction MIPS core. It owns the PC register, advances it on each accepted fetch, and resolves branch and jump requests from decode. Branch targets are PC+4 plus the sign-extended word offset (imm16 sign-extended, <<2). The block stalls when branch operands are not yet forwarded, and redirects to the exception vector on request.

Parameters:
RESET_VEC, 32'h0040_0000, PC value after reset.
EXC_VEC, 32'h0040_0004, PC loaded on exception or misaligned JR.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
imem_ready  in  1  fetch accepted this cycle; PC may advance.
pc  out  32  current fetch address.
fetch_valid  out  1  pc is a valid fetch request.
dec_valid  in  1  decode holds a control-transfer instruction this cycle.
dec_type  in  3  0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6 J/JAL, 7 JR/JALR.
dec_pc  in  32  PC of the instruction in decode.
imm16  in  16  branch offset field.
instr_index  in  26  J-format target field.
rs_val  in  32  rs operand (forwarded).
rt_val  in  32  rt operand (forwarded).
opnd_ready  in  1  rs_val/rt_val valid this cycle.
exc_req  in  1  exception request from later stages.
stall  out  1  freeze fetch/decode.
flush  out  1  squash the instruction in fetch.
exc_jr  out  1  one-cycle pulse: JR target misaligned.
taken_cnt  out  32  count of taken transfers.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- On reset: pc=RESET_VEC, state=RUN, fetch_valid=0 for the reset cycle and 1 afterwards. stall=0, flush=0, exc_jr=0, taken_cnt=0.
- States: RUN, BR_WAIT.
- RUN, no dec_valid: if imem_ready then pc<=pc+4; otherwise hold.
- RUN with dec_valid and opnd_ready=0: go to BR_WAIT. pc holds. stall=1 combinationally in that same cycle.
- BR_WAIT: stall=1 and pc holds. Decode inputs are held stable by the stall. Return to RUN in the cycle opnd_ready=1, resolving exactly as RUN does.
- Resolve (dec_valid and opnd_ready):
  - Branch condition: signed compare of rs_val and rt_val (zero for the single-operand types).
  - Branch target = dec_pc + 4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32.
  - J target = {dec_pc_plus4[31:28], instr_index, 2'b00}.
  - JR target = rs_val.
  - If taken: pc<=target, taken_cnt+=1 (wraps), flush per the delay-slot rule below.
  - If not taken: normal advance.
- JR with rs_val[1:0]!=0: pc<=EXC_VEC, exc_jr=1 for one cycle, flush=1. Not counted as taken.
- Redirects (taken, exception) load pc regardless of imem_ready.
- Priority: rst_n=0 > exc_req > resolve > sequential advance.
  - exc_req: pc<=EXC_VEC, flush=1, state<=RUN, dropping any pending branch.
- flush and exc_jr are registered one-cycle pulses.
- stall is combinational from state, dec_valid and opnd_ready.
- Reset mid-BR_WAIT returns to RUN and RESET_VEC next cycle.

Optional Feature:
BRANCH_DELAY_SLOT_EN
- Defined: the already-fetched instruction at dec_pc+4 executes as the delay slot. A taken redirect raises no flush.
- Undefined: a taken redirect raises flush=1 the next cycle to squash the wrong-path fetch.
- Exception redirect flushes in both builds.

Decomposition:
- Shared package mips_ctrl_pkg holds the dec_type encodings, the state enum, and the RESET_VEC/EXC_VEC defaults.
- One sub-module, branch_cond_eval: combinational taken/target computation, including the sign-extend-shift of imm16. The sequencer holds the registers and the FSM.

Test Plan:
- Reset: rst_n low 2 cycles, imem_ready=1 → pc=0x0040_0000, then 0x0040_0004, 0x0040_0008.
- BEQ taken, negative offset: dec_pc=0x0040_0010, imm16=0xFFFC, rs=rt=5 → pc=0x0040_0004, taken_cnt=1. flush=1 only if BRANCH_DELAY_SLOT_EN is undefined.
- BNE with operands late: opnd_ready=0 for 3 cycles, then rs=1, rt=1 → stall=1 for 3 cycles, pc held, then pc=dec_pc+8 (not taken), taken_cnt unchanged.
- J then JR:
  - J with dec_pc=0x0040_0020, index=0x010_0040 → pc=0x0040_0100.
  - JR with rs=0x0040_0102 → pc=EXC_VEC, exc_jr pulse.
- exc_req asserted in the same cycle as a taken BGEZ in BR_WAIT → pc=0x0040_0004, flush=1, taken_cnt unchanged, state RUN.
- Hold: imem_ready=0 for 4 cycles with no dec_valid → pc constant, no flush.
